// File: rtl/ups_pulse_gen_if.sv
// ups_pulse_gen_if
//   Connection between the UPS register bank and the pulse generator.
//   master : register bank side (drives data/dv, observes pulse/status)
//   slave  : pulse generator side
//   Signals:
//     data      [DW][32]  register-bank contents
//     dv        [DW]      one-cycle write strobes, one per register
//     pulse_out           generated pulse
//     busy                sequence running
//     status    [32]      status word
//     irq                 event interrupt (only with UPS_PGEN_IRQ_EN)
interface ups_pulse_gen_if #(
  parameter int unsigned DW = 16
);
  logic [DW-1:0][31:0] data;
  logic [DW-1:0]       dv;
  logic                pulse_out;
  logic                busy;
  logic [31:0]         status;
`ifdef UPS_PGEN_IRQ_EN
  logic                irq;

  modport master (output data, dv, input pulse_out, busy, status, irq);
  modport slave  (input data, dv, output pulse_out, busy, status, irq);
`else
  modport master (output data, dv, input pulse_out, busy, status);
  modport slave  (input data, dv, output pulse_out, busy, status);
`endif
endinterface

// File: rtl/ups_pulse_gen.sv
// ups_pulse_gen
//   Pulse-train generator fed by the UPS register bank. A CTRL write with
//   START latches DELAY/HIGH/LOW/COUNT/CONT and runs
//   IDLE -> DELAY -> HIGH -> LOW -> HIGH ... -> DONE -> IDLE on pulse_out.
//   Registers: CTRL=BASE, DELAY=BASE+1, HIGH=BASE+2, LOW=BASE+3, COUNT=BASE+4.
//   CTRL bits: [0] START, [1] CONT, [2] ABORT (ABORT wins over START).
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    ups_pulse_gen_if.slave (data/dv in; pulse_out/busy/status[/irq] out)
//   status: [0] busy [1] done [2] aborted [3] overrun [4] zero_err
//           [15:5] 0 [31:16] pulses emitted (saturating).
//   Optional feature macro: UPS_PGEN_IRQ_EN adds a one-cycle irq on entering
//   DONE, on abort of a busy sequence and on zero_err.
module ups_pulse_gen #(
  parameter int unsigned DW   = 16,
  parameter int unsigned BASE = 0,
  parameter int unsigned CW   = 32
) (
  input logic           clk,
  input logic           rst_n,
  ups_pulse_gen_if.slave bus
);
  localparam int unsigned IDX_DELAY = BASE + 1;
  localparam int unsigned IDX_HIGH  = BASE + 2;
  localparam int unsigned IDX_LOW   = BASE + 3;
  localparam int unsigned IDX_COUNT = BASE + 4;
  localparam logic [CW-1:0] ONE = 1;

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_HIGH, S_LOW, S_DONE} state_t;

  logic [DW-1:0][31:0] data_w;
  logic [DW-1:0]       dv_w;
  logic                unused_bits;
  logic                cmd_start, cmd_abort, cont_w;
  logic [CW-1:0]       delay_w, high_w, low_w, count_w;

  state_t        state_q;
  logic [CW-1:0] tmr_q, rem_q, high_s_q, low_s_q;
  logic          cont_s_q;
  logic [15:0]   pcnt_q;
  logic          pulse_q, busy_q, done_q, abt_q, ovr_q, zero_q;
`ifdef UPS_PGEN_IRQ_EN
  logic          irq_q;
`endif

  assign data_w      = bus.data;
  assign dv_w        = bus.dv;
  assign unused_bits = ^{data_w, dv_w};

  always_comb begin
    cmd_abort = dv_w[BASE] & data_w[BASE][2];
    cmd_start = dv_w[BASE] & data_w[BASE][0] & ~data_w[BASE][2];
    cont_w    = data_w[BASE][1];
    delay_w   = data_w[IDX_DELAY][CW-1:0];
    high_w    = data_w[IDX_HIGH][CW-1:0];
    low_w     = data_w[IDX_LOW][CW-1:0];
    count_w   = data_w[IDX_COUNT][CW-1:0];
  end

  // Timer reload for a phase lasting max(x,1) cycles.
  function automatic logic [CW-1:0] ld1(input logic [CW-1:0] x);
    return (x == '0) ? '0 : x - ONE;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      tmr_q    <= '0;
      rem_q    <= '0;
      high_s_q <= '0;
      low_s_q  <= '0;
      cont_s_q <= 1'b0;
      pcnt_q   <= '0;
      pulse_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      abt_q    <= 1'b0;
      ovr_q    <= 1'b0;
      zero_q   <= 1'b0;
`ifdef UPS_PGEN_IRQ_EN
      irq_q    <= 1'b0;
`endif
    end else begin
`ifdef UPS_PGEN_IRQ_EN
      irq_q <= 1'b0;
`endif
      if (cmd_abort && state_q != S_IDLE) begin
        state_q <= S_IDLE;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        abt_q   <= 1'b1;
`ifdef UPS_PGEN_IRQ_EN
        irq_q   <= 1'b1;
`endif
      end else begin
        if (cmd_start && state_q != S_IDLE) ovr_q <= 1'b1;
        case (state_q)
          S_IDLE: begin
            if (cmd_start) begin
              done_q   <= 1'b0;
              abt_q    <= 1'b0;
              ovr_q    <= 1'b0;
              zero_q   <= 1'b0;
              pcnt_q   <= '0;
              high_s_q <= high_w;
              low_s_q  <= low_w;
              cont_s_q <= cont_w;
              rem_q    <= count_w;
              if (count_w == '0 && !cont_w) begin
                zero_q <= 1'b1;
`ifdef UPS_PGEN_IRQ_EN
                irq_q  <= 1'b1;
`endif
              end else if (delay_w != '0) begin
                state_q <= S_DELAY;
                busy_q  <= 1'b1;
                tmr_q   <= delay_w - ONE;
              end else begin
                state_q <= S_HIGH;
                busy_q  <= 1'b1;
                pulse_q <= 1'b1;
                tmr_q   <= ld1(high_w);
              end
            end
          end
          S_DELAY: begin
            if (tmr_q == '0) begin
              state_q <= S_HIGH;
              pulse_q <= 1'b1;
              tmr_q   <= ld1(high_s_q);
            end else begin
              tmr_q <= tmr_q - ONE;
            end
          end
          S_HIGH: begin
            if (tmr_q == '0) begin
              pulse_q <= 1'b0;
              if (pcnt_q != 16'hFFFF) pcnt_q <= pcnt_q + 16'd1;
              // rem_q holds pulses still owed; the last pulse goes straight
              // to DONE so no trailing LOW phase is emitted.
              if (!cont_s_q && rem_q == ONE) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
`ifdef UPS_PGEN_IRQ_EN
                irq_q   <= 1'b1;
`endif
              end else begin
                state_q <= S_LOW;
                tmr_q   <= ld1(low_s_q);
                if (!cont_s_q) rem_q <= rem_q - ONE;
              end
            end else begin
              tmr_q <= tmr_q - ONE;
            end
          end
          S_LOW: begin
            if (tmr_q == '0) begin
              state_q <= S_HIGH;
              pulse_q <= 1'b1;
              tmr_q   <= ld1(high_s_q);
            end else begin
              tmr_q <= tmr_q - ONE;
            end
          end
          S_DONE: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            pulse_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.status    = {pcnt_q, 11'd0, zero_q, ovr_q, abt_q, done_q, busy_q};
`ifdef UPS_PGEN_IRQ_EN
  assign bus.irq       = irq_q;
`endif

endmodule
